nes_poll_sequencer: RTL and testbench

- Sequences the latch/clock protocol for both NES controllers and captures their serial button data once per video frame.
- Sits inside the Pong core between the pad pins and the paddle logic, triggered by the frame-start pulse from the VGA timing generator.
- Both pads are read in lockstep. Results are presented as two stable, active-high 8-bit button registers with a one-cycle valid strobe.

---
 rtl/nes_poll_sequencer.sv | 148 ++++++++++++++
 tb/tb_nes_poll_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_poll_sequencer.sv
// nes_poll_sequencer: drives the latch/clock protocol for two NES pads in
// lockstep and captures one 8-bit button snapshot per poll request.
//
// Handshake: start is a single-cycle request that is only honoured in IDLE.
// Requests seen while busy are dropped. valid is a one-cycle strobe, and
// buttons_p1/p2 change only in the cycle where valid is high.
//
// Poll timeline, counted in edges after the start edge E0:
//   E0                 : busy rises. nes_latch stays low while counters clear.
//   E0+1 .. E0+L       : nes_latch high (L = LATCH_CYCLES).
//   then 8 READ_LOW and 7 CLK_HIGH phases, each HALF_CYCLES long.
//   E0+L+15*HALF+1     : DONE, valid high, buttons updated.
//   one IDLE cycle, after which the next request can be taken.
module nes_poll_sequencer #(
  parameter int LATCH_CYCLES = 300,
  parameter int HALF_CYCLES  = 150
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       nes_data_p1,
  input  logic       nes_data_p2,
  output logic       nes_latch,
  output logic       nes_clk,
  output logic [7:0] buttons_p1,
  output logic [7:0] buttons_p2,
  output logic       valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LATCH    = 3'd1,
    READ_LOW = 3'd2,
    CLK_HIGH = 3'd3,
    DONE     = 3'd4
  } state_t;

  // The LATCH state holds a setup cycle (cnt=0) and then LATCH_CYCLES latch cycles.
  localparam logic [9:0] LATCH_LAST = 10'(LATCH_CYCLES);
  localparam logic [9:0] HALF_LAST  = 10'(HALF_CYCLES - 1);

  state_t     state, state_n;
  logic [9:0] cnt, cnt_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift_p1, shift_p1_n;
  logic [7:0] shift_p2, shift_p2_n;
  logic [1:0] sync_p1, sync_p2;
  logic       latch_n, clk_n, valid_n, busy_n;

  // Next-state, counter and shift-register logic.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_cnt_n  = bit_cnt;
    shift_p1_n = shift_p1;
    shift_p2_n = shift_p2;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = LATCH;
          cnt_n   = '0;
        end
      end
      LATCH: begin
        bit_cnt_n = '0;
        if (cnt == LATCH_LAST) begin
          state_n = READ_LOW;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 10'd1;
        end
      end
      READ_LOW: begin
        if (cnt == HALF_LAST) begin
          // Pads drive active-low data; store pressed as 1, first bit ends up in bit 7.
          shift_p1_n = {shift_p1[6:0], ~sync_p1[1]};
          shift_p2_n = {shift_p2[6:0], ~sync_p2[1]};
          bit_cnt_n  = bit_cnt + 4'd1;
          cnt_n      = '0;
          state_n    = (bit_cnt == 4'd7) ? DONE : CLK_HIGH;
        end else begin
          cnt_n = cnt + 10'd1;
        end
      end
      CLK_HIGH: begin
        if (cnt == HALF_LAST) begin
          state_n = READ_LOW;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 10'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Output values for the next cycle, decoded from the next state so every output is a flop.
  always_comb begin
    latch_n = (state_n == LATCH) && (cnt_n != 10'd0);
    clk_n   = (state_n == CLK_HIGH);
    valid_n = (state_n == DONE);
    busy_n  = (state_n != IDLE);
  end

  // State, counters, synchronisers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shift_p1   <= '0;
      shift_p2   <= '0;
      sync_p1    <= '0;
      sync_p2    <= '0;
      nes_latch  <= 1'b0;
      nes_clk    <= 1'b0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      buttons_p1 <= '0;
      buttons_p2 <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_cnt   <= bit_cnt_n;
      shift_p1  <= shift_p1_n;
      shift_p2  <= shift_p2_n;
      sync_p1   <= {sync_p1[0], nes_data_p1};
      sync_p2   <= {sync_p2[0], nes_data_p2};
      nes_latch <= latch_n;
      nes_clk   <= clk_n;
      valid     <= valid_n;
      busy      <= busy_n;
      if (state_n == DONE) begin
        buttons_p1 <= shift_p1_n;
        buttons_p2 <= shift_p2_n;
      end
    end
  end

endmodule

// File: tb/tb_nes_poll_sequencer.sv
// Bench for nes_poll_sequencer with LATCH_CYCLES=4, HALF_CYCLES=3.
module tb_nes_poll_sequencer;
  localparam int L   = 4;
  localparam int H   = 3;
  localparam int LAT = L + 15 * H + 1;  // edges from start edge to valid cycle

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset, start;
  logic nes_data_p1, nes_data_p2;
  logic nes_latch, nes_clk, valid, busy;
  logic [7:0] buttons_p1, buttons_p2;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  nes_poll_sequencer #(.LATCH_CYCLES(L), .HALF_CYCLES(H)) dut (
    .clk(clk), .reset(reset), .start(start),
    .nes_data_p1(nes_data_p1), .nes_data_p2(nes_data_p2),
    .nes_latch(nes_latch), .nes_clk(nes_clk),
    .buttons_p1(buttons_p1), .buttons_p2(buttons_p2),
    .valid(valid), .busy(busy)
  );

  // ---------------- pad model (4021-style shift register) ----------------
  logic [7:0] pad1 = 8'h00, pad2 = 8'h00;  // pressed buttons, 1 = pressed
  int idx = 0;
  always @(posedge nes_latch or posedge nes_clk) begin
    if (nes_latch) idx <= 0;
    else if (idx < 8) idx <= idx + 1;
  end
  assign nes_data_p1 = (idx < 8) ? ~pad1[7 - idx] : 1'b0;
  assign nes_data_p2 = (idx < 8) ? ~pad2[7 - idx] : 1'b0;

  // ---------------- scoreboard ----------------
  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int         t;
    logic [7:0] b1;
    logic [7:0] b2;
  } exp_rec_t;
  exp_rec_t exp_q[$];
  exp_rec_t mon_e;
  exp_rec_t new_e;

  bit rnd_on = 1'b0;
  int last_e0 = -1000;
  int next_free = 0;
  int valid_cnt = 0, latch_rises = 0;
  logic prev_latch = 1'b0;
  logic busy_exp;

  // Monitor: counts strobes and, in the random phase, checks against the reference model.
  always @(negedge clk) begin
    if (valid) valid_cnt++;
    if (nes_latch && !prev_latch) latch_rises++;
    prev_latch = nes_latch;
    if (rnd_on) begin
      busy_exp = (cyc >= last_e0) && (cyc <= last_e0 + LAT);
      chk("rnd_busy", 32'(busy), 32'(busy_exp));
      if (valid) begin
        if (exp_q.size() == 0) chk("rnd_unexpected_valid", 32'(valid), 32'd0);
        else begin
          mon_e = exp_q.pop_front();
          chk("rnd_valid_time", cyc, mon_e.t);
          chk("rnd_p1", 32'(buttons_p1), 32'(mon_e.b1));
          chk("rnd_p2", 32'(buttons_p2), 32'(mon_e.b2));
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].t) begin
        chk("rnd_missing_valid", 32'(valid), 32'd1);
        mon_e = exp_q.pop_front();
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [7:0] prev1 = 8'h00, prev2 = 8'h00;

  task automatic do_poll(input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] e1, input logic [7:0] e2, input string name);
    int k, lat_n, pulses, hi_n, hold_bad;
    logic pc;
    pad1 = b1;
    pad2 = b2;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0; lat_n = 0; pulses = 0; hi_n = 0; hold_bad = 0; pc = 1'b0;
    chk({name, "_busy_at_e0"}, 32'(busy), 32'd1);
    while (!valid && k < 200) begin
      if (nes_latch) lat_n++;
      if (nes_clk) hi_n++;
      if (nes_clk && !pc) pulses++;
      pc = nes_clk;
      if (buttons_p1 !== prev1 || buttons_p2 !== prev2) hold_bad++;
      @(posedge clk);
      #1 k++;
    end
    chk({name, "_latency"}, k, LAT);
    chk({name, "_latch_cycles"}, lat_n, L);
    chk({name, "_clk_pulses"}, pulses, 7);
    chk({name, "_clk_high_cycles"}, hi_n, 7 * H);
    chk({name, "_hold_before"}, hold_bad, 0);
    chk({name, "_p1"}, 32'(buttons_p1), 32'(e1));
    chk({name, "_p2"}, 32'(buttons_p2), 32'(e2));
    prev1 = e1;
    prev2 = e2;
    @(posedge clk);
    #1;
    chk({name, "_valid_one_cycle"}, 32'(valid), 32'd0);
    chk({name, "_idle_after"}, 32'(busy), 32'd0);
    chk({name, "_hold_after"}, {16'h0, buttons_p1, buttons_p2}, {16'h0, e1, e2});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] e1;
    logic [7:0] e2;
    string      name;
  } vec_t;
  vec_t vecs[5];

  int v0, lr0, bad, e0, idle_between, nvalid;
  int vt[3];

  initial begin
    vecs[0] = '{8'h81, 8'h18, 8'h81, 8'h18, "basic"};
    vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h00, "all_released"};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, "all_pressed"};
    vecs[3] = '{8'hA5, 8'h5A, 8'hA5, 8'h5A, "alt"};
    vecs[4] = '{8'h01, 8'h80, 8'h01, 8'h80, "edges"};

    // reset and idle
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_latch", 32'(nes_latch), 32'd0);
    chk("rst_clk", 32'(nes_clk), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_buttons", {16'h0, buttons_p1, buttons_p2}, 32'd0);
    @(negedge clk) reset = 1'b0;
    bad = 0;
    repeat (50) @(negedge clk) if (nes_latch || nes_clk || busy || valid) bad++;
    chk("idle_quiet", bad, 0);

    // table-driven polls
    for (int i = 0; i < 5; i++) do_poll(vecs[i].b1, vecs[i].b2, vecs[i].e1, vecs[i].e2, vecs[i].name);

    // start while busy is ignored
    v0 = valid_cnt;
    lr0 = latch_rises;
    pad1 = 8'h3C;
    pad2 = 8'hC3;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (80) @(negedge clk);
    chk("busy_start_valids", valid_cnt - v0, 1);
    chk("busy_start_latches", latch_rises - lr0, 1);
    chk("busy_start_data", {16'h0, buttons_p1, buttons_p2}, 32'h3CC3);

    // start held high: three back-to-back polls
    pad1 = 8'h42;
    pad2 = 8'h24;
    @(negedge clk);
    e0 = cyc + 1;
    start = 1'b1;
    nvalid = 0;
    idle_between = 0;
    for (int n = 0; n < 300 && nvalid < 3; n++) begin
      @(negedge clk);
      if (nvalid == 1 && !busy) idle_between++;
      if (valid) begin
        vt[nvalid] = cyc;
        nvalid++;
        chk("cont_data", {16'h0, buttons_p1, buttons_p2}, 32'h4224);
      end
    end
    start = 1'b0;
    chk("cont_count", nvalid, 3);
    chk("cont_first", vt[0] - e0, LAT);
    chk("cont_gap1", vt[1] - vt[0], LAT + 2);
    chk("cont_gap2", vt[2] - vt[1], LAT + 2);
    chk("cont_idle_cycles", idle_between, 1);
    repeat (60) @(negedge clk);
    chk("cont_no_fourth", 32'(busy), 32'd0);

    // reset during the 4th CLK_HIGH phase
    pad1 = 8'hFF;
    pad2 = 8'hFF;
    @(negedge clk);
    e0 = cyc + 1;
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    while (cyc < e0 + 26) @(negedge clk);
    chk("mid_clk_high", 32'(nes_clk), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_clk", 32'(nes_clk), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_latch", 32'(nes_latch), 32'd0);
    chk("mid_rst_buttons", {16'h0, buttons_p1, buttons_p2}, 32'd0);
    v0 = valid_cnt;
    @(negedge clk) reset = 1'b0;
    repeat (60) @(negedge clk);
    chk("mid_rst_no_valid", valid_cnt - v0, 0);
    prev1 = 8'h00;
    prev2 = 8'h00;
    do_poll(8'h81, 8'h18, 8'h81, 8'h18, "after_reset");

    // random requests against the reference model
    @(negedge clk);
    next_free = cyc + 1;
    rnd_on = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      if (start && (cyc + 1) >= next_free) begin
        pad1 = 8'($urandom);
        pad2 = 8'($urandom);
        last_e0 = cyc + 1;
        next_free = cyc + 1 + LAT + 2;
        new_e.t = cyc + 1 + LAT;
        new_e.b1 = pad1;
        new_e.b2 = pad2;
        exp_q.push_back(new_e);
      end
    end
    @(negedge clk) start = 1'b0;
    repeat (60) @(negedge clk);
    chk("rnd_queue_drained", exp_q.size(), 0);
    rnd_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
